// File: rtl/axi_decerr_slave.sv
// axi_decerr_slave: AXI sink that accepts every burst and answers DECERR with zero read data.
// Write and read channels run independent FSMs; all outputs come straight from flops.
module axi_decerr_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  cpl_wr_valid,
    output logic                  cpl_rd_valid
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [7:0] cnt, cnt_next;
    logic aw_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last_hs;
    logic awready_d, wready_d, bvalid_d, arready_d, rvalid_d, rlast_d, cpl_wr_d, cpl_rd_d;
    assign aw_hs       = s_axi_awvalid & s_axi_awready;
    assign w_last_hs   = s_axi_wvalid & s_axi_wready & s_axi_wlast;
    assign b_hs        = s_axi_bvalid & s_axi_bready;
    assign ar_hs       = s_axi_arvalid & s_axi_arready;
    assign r_hs        = s_axi_rvalid & s_axi_rready;
    assign r_last_hs   = r_hs & s_axi_rlast;
    assign s_axi_bresp = 2'b11;
    assign s_axi_rresp = 2'b11;
    assign s_axi_rdata = '0;
    always_comb begin
        w_next   = (w_state == W_IDLE && aw_hs)     ? W_DATA :
                   (w_state == W_DATA && w_last_hs) ? W_RESP :
                   (w_state == W_RESP && b_hs)      ? W_IDLE : w_state;
        r_next   = (r_state == R_IDLE && ar_hs)     ? R_DATA :
                   (r_state == R_DATA && r_last_hs) ? R_IDLE : r_state;
        cnt_next = ar_hs ? s_axi_arlen : (r_hs && !s_axi_rlast) ? cnt - 8'd1 : cnt;
    end
    // Output flops are loaded from next-state values so every output is registered.
    always_comb begin
        awready_d = w_next == W_IDLE;
        wready_d  = w_next == W_DATA;
        bvalid_d  = w_next == W_RESP;
        arready_d = r_next == R_IDLE;
        rvalid_d  = r_next == R_DATA;
        rlast_d   = r_next == R_DATA && cnt_next == 8'd0;
        cpl_wr_d  = b_hs;
        cpl_rd_d  = r_last_hs;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            r_state       <= R_IDLE;
            cnt           <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            cpl_wr_valid  <= 1'b0;
            cpl_rd_valid  <= 1'b0;
        end else begin
            w_state       <= w_next;
            r_state       <= r_next;
            cnt           <= cnt_next;
            s_axi_awready <= awready_d;
            s_axi_wready  <= wready_d;
            s_axi_bvalid  <= bvalid_d;
            s_axi_bid     <= aw_hs ? s_axi_awid : s_axi_bid;
            s_axi_arready <= arready_d;
            s_axi_rvalid  <= rvalid_d;
            s_axi_rlast   <= rlast_d;
            s_axi_rid     <= ar_hs ? s_axi_arid : s_axi_rid;
            cpl_wr_valid  <= cpl_wr_d;
            cpl_rd_valid  <= cpl_rd_d;
        end
    end
endmodule

// File: doc/axi_decerr_slave.md
AXI_DECERR_SLAVE -- requirements
Module: axi_decerr_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, R data width in bits.
REQ-002 SHALL have parameter ID_WIDTH, default 8, AXI ID field width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_axi_awid  input  ID_WIDTH  write address ID.
REQ-006 SHALL have port s_axi_awvalid  input  1  write address valid.
REQ-007 SHALL have port s_axi_awready  output  1  write address ready.
REQ-008 SHALL have port s_axi_wlast  input  1  last write beat; W data/strobe not consumed.
REQ-009 SHALL have port s_axi_wvalid  input  1  write data valid.
REQ-010 SHALL have port s_axi_wready  output  1  write data ready.
REQ-011 SHALL have port s_axi_bid  output  ID_WIDTH  write response ID.
REQ-012 SHALL have port s_axi_bresp  output  2  write response, constant 2'b11 (DECERR).
REQ-013 SHALL have port s_axi_bvalid  output  1  write response valid.
REQ-014 SHALL have port s_axi_bready  input  1  write response ready.
REQ-015 SHALL have port s_axi_arid  input  ID_WIDTH  read address ID.
REQ-016 SHALL have port s_axi_arlen  input  8  read burst length minus one.
REQ-017 SHALL have port s_axi_arvalid  input  1  read address valid.
REQ-018 SHALL have port s_axi_arready  output  1  read address ready.
REQ-019 SHALL have port s_axi_rid  output  ID_WIDTH  read data ID.
REQ-020 SHALL have port s_axi_rdata  output  DATA_WIDTH  read data, constant zero.
REQ-021 SHALL have port s_axi_rresp  output  2  read response, constant 2'b11 (DECERR).
REQ-022 SHALL have port s_axi_rlast  output  1  last read beat.
REQ-023 SHALL have port s_axi_rvalid  output  1  read data valid.
REQ-024 SHALL have port s_axi_rready  input  1  read data ready.
REQ-025 SHALL have ports cpl_wr_valid / cpl_rd_valid  output  1 each  one-cycle completion pulses.

Function
REQ-026 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM SHALL have states R_IDLE, R_DATA; both independent and concurrently active.
REQ-027 W_IDLE: awready=1, wready=0; on AW handshake latch awid into bid, go W_DATA; awready=0 next cycle.
REQ-028 W_DATA: wready=1; beats discarded; on handshake with wlast=1 go W_RESP, wready=0 and bvalid=1 next cycle.
REQ-029 W beats presented before AW acceptance SHALL stall (wready=0); W beat count is not checked against AWLEN, wlast alone ends the burst.
REQ-030 W_RESP: bvalid held with bid stable until bready; on B handshake cpl_wr_valid=1 next cycle, return W_IDLE, awready=1 next cycle.
REQ-031 R_IDLE: arready=1; on AR handshake latch arid, load 8-bit beat counter with arlen, go R_DATA; rvalid=1 next cycle.
REQ-032 R_DATA: rvalid=1, rlast=1 iff counter==0; counter decrements on each R handshake; rid/rlast stable while rready=0.
REQ-033 Handshake with rlast=1 SHALL return R_IDLE, rvalid=0 and arready=1 next cycle, cpl_rd_valid=1 next cycle.
REQ-034 arlen=0 SHALL yield exactly one beat with rlast=1; arlen=255 SHALL yield exactly 256 beats with no counter wrap.
REQ-035 Minimum turnaround: one idle cycle between end of one burst and acceptance of the next on each channel; at most one outstanding transaction per channel.
REQ-036 All outputs SHALL be registered; no combinational path input-to-output.

Reset
REQ-037 On rst_n low, both FSMs SHALL go idle asynchronously: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, cpl_*=0, bid=rid=0, counter=0; in-flight transactions discarded.
REQ-038 awready and arready SHALL rise one cycle after rst_n deasserts.

Verification
REQ-039 AW id=0x5A, 4 W beats (wlast on 4th), bready=1 -> bvalid 1 cycle after 4th beat, bid=0x5A, bresp=2'b11, cpl_wr_valid pulse 1 cycle after B handshake.
REQ-040 AR id=0x3C arlen=3, rready=1 -> 4 beats on consecutive cycles, rdata=0, rresp=2'b11, rlast only on beat 4, cpl_rd_valid once.
REQ-041 AR arlen=255 with rready toggling every cycle -> exactly 256 beats, rid/rlast stable during stalls.
REQ-042 Concurrent AW+AR same cycle, bready held low 10 cycles -> read burst completes unaffected; bvalid held 10 cycles.
REQ-043 W beats with no AW for 5 cycles -> wready=0 throughout, no B issued.
REQ-044 rst_n pulled low mid-read (beat 2 of 8) -> rvalid=0 immediately; after release arready=1 next cycle, no residual beats.
